// File: rtl/seg_digit_writer_if.sv
// Handshake and digit-latch bus between the value source,
// the seg_digit_writer, and the display latch bank.
interface seg_digit_writer_if #(
    parameter int NUM_DIGITS = 6
);
    localparam int SEL_W =
        (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    start;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    busy;
    logic                    done;
    logic                    io_flag;
    logic [SEL_W-1:0]        digit_sel;
    logic [6:0]              seg_out;

    modport master (
        output start, value,
        input  busy, done, io_flag, digit_sel, seg_out
    );

    modport slave (
        input  start, value,
        output busy, done, io_flag, digit_sel, seg_out
    );
endinterface

// File: rtl/seg_digit_writer.sv
// Writes a packed hex value to the 7-seg latches, one strobe per digit, LSD first.
// Define SEG_LEADING_BLANK_EN to blank digits above the most significant nonzero one.
module seg_digit_writer #(
    parameter int NUM_DIGITS = 6,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    seg_digit_writer_if.slave bus
);
    localparam int SEL_W =
        (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [SEL_W-1:0] LAST_K =
        SEL_W'(NUM_DIGITS - 1);
    localparam logic [7:0] GAP_LAST =
        8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE, WRITE, GAP, DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [VW-1:0]    value_q;
    logic [SEL_W-1:0] k_q;
    logic [7:0]       gap_q;
    logic [6:0]       seg_q;
    logic [3:0]       nib;
    logic [6:0]       seg_cur;

    function automatic logic [6:0] enc(input logic [3:0] n);
        unique case (n)
            4'h0: enc = 7'h40;
            4'h1: enc = 7'h79;
            4'h2: enc = 7'h24;
            4'h3: enc = 7'h30;
            4'h4: enc = 7'h19;
            4'h5: enc = 7'h12;
            4'h6: enc = 7'h02;
            4'h7: enc = 7'h78;
            4'h8: enc = 7'h00;
            4'h9: enc = 7'h10;
            4'hA: enc = 7'h08;
            4'hB: enc = 7'h03;
            4'hC: enc = 7'h46;
            4'hD: enc = 7'h21;
            4'hE: enc = 7'h06;
            4'hF: enc = 7'h0E;
            default: enc = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.start) state_nx = WRITE;
            WRITE: begin
                if (k_q == LAST_K)        state_nx = DONE;
                else if (GAP_CYCLES == 0) state_nx = WRITE;
                else                      state_nx = GAP;
            end
            GAP:   if (gap_q == GAP_LAST) state_nx = WRITE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Digit index only advances on a real hand-off to the next WRITE,
    // so it never passes LAST_K and gap_q never passes GAP_LAST.
    always_ff @(posedge clk) begin
        if (!reset) begin
            value_q <= '0;
            k_q     <= '0;
            gap_q   <= '0;
            seg_q   <= 7'h7F;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        value_q <= bus.value;
                        k_q     <= '0;
                    end
                end
                WRITE: begin
                    seg_q <= seg_cur;
                    gap_q <= '0;
                    if (k_q != LAST_K && GAP_CYCLES == 0)
                        k_q <= k_q + 1'b1;
                end
                GAP: begin
                    if (gap_q == GAP_LAST) k_q <= k_q + 1'b1;
                    else                   gap_q <= gap_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign nib = value_q[{k_q, 2'b00} +: 4];

`ifdef SEG_LEADING_BLANK_EN
    logic [SEL_W-1:0] msd;

    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (value_q[4*i +: 4] != 4'h0) msd = SEL_W'(i);
    end

    assign seg_cur = (k_q > msd) ? 7'h7F : enc(nib);
`else
    assign seg_cur = enc(nib);
`endif

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.io_flag   = (state == WRITE);
        bus.digit_sel = k_q;
        bus.seg_out   = (state == WRITE) ? seg_cur : seg_q;
    end
endmodule

// File: tb/tb_seg_digit_writer.sv
// Scoreboard bench: one writer with no gap, one with GAP_CYCLES=2.
// Expected strobes/done are queued at start acceptance and checked by a monitor.
module tb_seg_digit_writer;
    typedef struct {
        int         cyc;
        bit         is_done;
        logic [2:0] sel;
        logic [6:0] seg;
    } exp_t;

`ifdef SEG_LEADING_BLANK_EN
    localparam logic [6:0] Z = 7'h7F;
`else
    localparam logic [6:0] Z = 7'h40;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   edge_cnt = 0;
    logic rst_seen = 1'b0;
    bit   end_chk = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   win_lo [2] = '{1, 1};
    int   win_hi [2] = '{0, 0};
    exp_t q0 [$];
    exp_t q1 [$];

    seg_digit_writer_if #(.NUM_DIGITS(6)) bus0 ();
    seg_digit_writer_if #(.NUM_DIGITS(6)) bus1 ();

    seg_digit_writer #(.NUM_DIGITS(6), .GAP_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    seg_digit_writer #(.NUM_DIGITS(6), .GAP_CYCLES(2)) u1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_seen <= !reset;
    end

    task automatic rchk(input int d, input logic iof, dn, bsy,
                        input logic [2:0] sel, input logic [6:0] seg);
        n_vec++;
        if (iof !== 1'b0 || dn !== 1'b0 || bsy !== 1'b0 ||
            sel !== 3'd0 || seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: got io=%b done=%b busy=%b sel=%0d seg=%h want 0 0 0 0 7f",
                     d, iof, dn, bsy, sel, seg);
        end
    endtask

    task automatic mon(input int d, input logic iof, dn, bsy,
                       input logic [2:0] sel, input logic [6:0] seg);
        exp_t e;
        logic eb;
        eb = (edge_cnt >= win_lo[d]) && (edge_cnt <= win_hi[d]);
        n_vec++;
        if (bsy !== eb) begin
            n_bad++;
            $display("FAIL busy dut%0d cyc %0d: got %b want %b",
                     d, edge_cnt, bsy, eb);
        end
        if (iof === 1'b1) begin
            n_vec++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_bad++;
                $display("FAIL strobe dut%0d cyc %0d: got unexpected sel=%0d seg=%h want none",
                         d, edge_cnt, sel, seg);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (e.is_done || e.cyc != edge_cnt || sel !== e.sel || seg !== e.seg) begin
                    n_bad++;
                    $display("FAIL strobe dut%0d: got cyc %0d sel=%0d seg=%h want cyc %0d sel=%0d seg=%h done=%b",
                             d, edge_cnt, sel, seg, e.cyc, e.sel, e.seg, e.is_done);
                end
            end
        end
        if (dn === 1'b1) begin
            n_vec++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_bad++;
                $display("FAIL done dut%0d cyc %0d: got unexpected done want none",
                         d, edge_cnt);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (!e.is_done || e.cyc != edge_cnt) begin
                    n_bad++;
                    $display("FAIL done dut%0d: got done at cyc %0d want cyc %0d done=%b",
                             d, edge_cnt, e.cyc, e.is_done);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (end_chk) begin
            n_vec += 2;
            if (q0.size() != 0) begin
                n_bad++;
                $display("FAIL drain dut0: got %0d pending want 0", q0.size());
            end
            if (q1.size() != 0) begin
                n_bad++;
                $display("FAIL drain dut1: got %0d pending want 0", q1.size());
            end
        end else begin
            if (rst_seen) begin
                rchk(0, bus0.io_flag, bus0.done, bus0.busy,
                     bus0.digit_sel, bus0.seg_out);
                rchk(1, bus1.io_flag, bus1.done, bus1.busy,
                     bus1.digit_sel, bus1.seg_out);
            end
            mon(0, bus0.io_flag, bus0.done, bus0.busy,
                bus0.digit_sel, bus0.seg_out);
            mon(1, bus1.io_flag, bus1.done, bus1.busy,
                bus1.digit_sel, bus1.seg_out);
        end
    end

    // segs packs the hand-computed patterns {d5,d4,d3,d2,d1,d0}.
    task automatic go(input int d, input logic [23:0] v,
                      input logic [41:0] segs);
        int   t;
        int   g;
        exp_t e;
        g = (d == 0) ? 0 : 2;
        if (d == 0) begin bus0.start = 1'b1; bus0.value = v; end
        else        begin bus1.start = 1'b1; bus1.value = v; end
        @(posedge clk);
        #1;
        t = edge_cnt;
        if (d == 0) bus0.start = 1'b0;
        else        bus1.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            e.cyc     = t + k * (g + 1);
            e.is_done = 1'b0;
            e.sel     = 3'(k);
            e.seg     = segs[7*k +: 7];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        e.cyc     = t + 5 * (g + 1) + 1;
        e.is_done = 1'b1;
        e.sel     = 3'd0;
        e.seg     = 7'h00;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        win_lo[d] = t;
        win_hi[d] = e.cyc;
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((d == 0 && bus0.done === 1'b1) ||
                (d == 1 && bus1.done === 1'b1)) return;
        end
        $display("FAIL wait_done dut%0d: got no done in 100 cycles want done", d);
        $fatal(1, "timeout");
    endtask

    localparam logic [41:0] S_12AB0F =
        {7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E};
    localparam logic [41:0] S_987654 =
        {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19};
    localparam logic [41:0] S_000000 =
        {Z, Z, Z, Z, Z, 7'h40};
    localparam logic [41:0] S_00003C =
        {Z, Z, Z, Z, 7'h30, 7'h46};
    localparam logic [41:0] S_0A0000 =
        {Z, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40};

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        exp_t tmp [$];
        bus0.start = 1'b0; bus0.value = '0;
        bus1.start = 1'b0; bus1.value = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        go(0, 24'h12AB0F, S_12AB0F);
        wait_done(0);
        @(negedge clk);
        go(0, 24'h987654, S_987654);
        wait_done(0);

        @(negedge clk);
        go(0, 24'h12AB0F, S_12AB0F);
        @(negedge clk);
        @(negedge clk);
        bus0.start = 1'b1;
        bus0.value = 24'hFFFFFF;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(0);
        repeat (10) @(negedge clk);

        go(1, 24'h000000, S_000000);
        wait_done(1);
        repeat (3) @(negedge clk);

        go(0, 24'h00003C, S_00003C);
        wait_done(0);
        @(negedge clk);
        go(0, 24'h000000, S_000000);
        wait_done(0);
        @(negedge clk);
        go(0, 24'h0A0000, S_0A0000);
        wait_done(0);
        @(negedge clk);

        go(0, 24'h12AB0F, S_12AB0F);
        repeat (3) @(negedge clk);
        c = edge_cnt;
        tmp = {};
        foreach (q0[i]) if (q0[i].cyc <= c) tmp.push_back(q0[i]);
        q0 = tmp;
        win_hi[0] = c;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        go(0, 24'h00003C, S_00003C);
        wait_done(0);

        repeat (5) @(negedge clk);
        end_chk = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
